// File: rtl/display_pkg.sv
// Shared constants for the watch display multiplexer: blank code, 7-seg letter
// codes and the default mode-name banners (index 0 = leftmost digit).
package display_pkg;

    localparam int         CODE_W_STD = 5;
    localparam logic [4:0] CODE_BLANK = 5'd31;

    localparam logic [4:0] CODE_L = 5'd11;
    localparam logic [4:0] CODE_C = 5'd12;
    localparam logic [4:0] CODE_P = 5'd13;
    localparam logic [4:0] CODE_T = 5'd14;
    localparam logic [4:0] CODE_S = 5'd15;
    localparam logic [4:0] CODE_R = 5'd16;
    localparam logic [4:0] CODE_A = 5'd17;
    localparam logic [4:0] CODE_N = 5'd18;
    localparam logic [4:0] CODE_U = 5'd19;
    localparam logic [4:0] CODE_O = 5'd20;

    typedef enum logic [1:0] {
        MODE_CLOCK,
        MODE_STOPWATCH,
        MODE_ALARM,
        MODE_COUNTDOWN
    } mode_e;

    // Packed with digit 0 in the least significant field, so literals read right-to-left.
    localparam logic [19:0] BANNER_CLOCK     = {CODE_C, CODE_O, CODE_L, CODE_C};     // "CLOC"
    localparam logic [19:0] BANNER_STOPWATCH = {CODE_P, CODE_O, CODE_T, CODE_S};     // "StOP"
    localparam logic [19:0] BANNER_ALARM     = {CODE_R, CODE_A, CODE_L, CODE_A};     // "ALAr"
    localparam logic [19:0] BANNER_COUNTDOWN = {CODE_BLANK, CODE_T, CODE_N, CODE_C}; // "Cnt "

    localparam logic [79:0] BANNER_DEFAULT =
        {BANNER_COUNTDOWN, BANNER_ALARM, BANNER_STOPWATCH, BANNER_CLOCK};

endpackage

// File: rtl/display_scan_mux_scan_timer.sv
// Digit-scan timebase: prescaler, digit index and a one-cycle frame_end pulse
// asserted on the cycle whose clock edge wraps the index back to digit 0.
module scan_timer #(
    parameter int  NUM_DIGITS = 4,
    parameter int  SCAN_DIV   = 1000,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx_o,
    output logic             frame_end_o
);

    localparam int PRE_W = $clog2(SCAN_DIV);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pre_wrap;
    logic             idx_last;

    assign pre_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));
    assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_wrap) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o       = idx_q;
    assign frame_end_o = pre_wrap && idx_last;

endmodule

// File: rtl/display_scan_mux.sv
// Multiplexed BCD display driver with per-mode source select and a timed
// mode-name banner. Define DISPLAY_LZS_EN for leading-zero suppression.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int  NUM_DIGITS    = 4,
    parameter int  NUM_SRC       = 4,
    parameter int  SCAN_DIV      = 1000,
    parameter int  BANNER_FRAMES = 256,
    parameter int  CODE_W        = CODE_W_STD,
    localparam int SEL_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SRC*NUM_DIGITS*4-1:0]      src_digits,
    input  logic [NUM_SRC*NUM_DIGITS*CODE_W-1:0] name_codes,
    input  logic [SEL_W-1:0]                   mode_sel,
    input  logic                               name_req,
    output logic [CODE_W-1:0]                  digit_code,
    output logic [NUM_DIGITS-1:0]              digit_en,
    output logic                               banner_active
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BAN_W = $clog2(BANNER_FRAMES + 1);
    localparam logic [CODE_W-1:0] BLANK = '1;

    logic [IDX_W-1:0]  idx;
    logic              frame_end;
    logic [SEL_W-1:0]  mode_q, mode_d;
    logic [BAN_W-1:0]  ban_cnt_q, ban_cnt_d;
    logic              mode_valid;
    logic              mode_load;
    logic              banner;
    logic              suppress;
    logic [3:0]        nib_cur;
    logic [CODE_W-1:0] code_q, code_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic              banner_q;

    logic [3:0]        nib_a  [NUM_SRC][NUM_DIGITS];
    logic [CODE_W-1:0] name_a [NUM_SRC][NUM_DIGITS];

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_o       (idx),
        .frame_end_o (frame_end)
    );

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
            assign nib_a[s][d]  = src_digits[(s*NUM_DIGITS + d)*4 +: 4];
            assign name_a[s][d] = name_codes[(s*NUM_DIGITS + d)*CODE_W +: CODE_W];
        end
    end

    // A power-of-two source count makes every select value legal.
    if (NUM_SRC == (1 << SEL_W)) begin : g_sel_full
        assign mode_valid = 1'b1;
    end else begin : g_sel_part
        assign mode_valid = (int'(mode_sel) < NUM_SRC);
    end

    always_comb begin
        mode_load = mode_valid && (mode_sel != mode_q);
        mode_d    = mode_load ? mode_sel : mode_q;
        ban_cnt_d = ban_cnt_q;
        if (mode_load) begin
            ban_cnt_d = BAN_W'(BANNER_FRAMES);
        end else if (frame_end && (ban_cnt_q != '0)) begin
            ban_cnt_d = ban_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            ban_cnt_q <= '0;
        end else begin
            mode_q    <= mode_d;
            ban_cnt_q <= ban_cnt_d;
        end
    end

    assign banner  = (ban_cnt_q != '0) || name_req;
    assign nib_cur = nib_a[mode_q][idx];

`ifdef DISPLAY_LZS_EN
    logic [NUM_DIGITS-1:0] nz_cur;
    logic                  lead_zero;

    // Any nonzero nibble (including 10-15) ends the leading-zero run.
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_nz
        assign nz_cur[d] = (nib_a[mode_q][d] != 4'd0);
    end

    always_comb begin
        lead_zero = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if ((d <= int'(idx)) && nz_cur[d]) begin
                lead_zero = 1'b0;
            end
        end
        suppress = lead_zero && (idx != IDX_W'(NUM_DIGITS - 1));
    end
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        en_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
        if (banner) begin
            code_d = name_a[mode_q][idx];
        end else if ((nib_cur > 4'd9) || suppress) begin
            code_d = BLANK;
        end else begin
            code_d = CODE_W'(nib_cur);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q   <= BLANK;
            en_q     <= '0;
            banner_q <= 1'b0;
        end else begin
            code_q   <= code_d;
            en_q     <= en_d;
            banner_q <= banner;
        end
    end

    assign digit_code    = code_q;
    assign digit_en      = en_q;
    assign banner_active = banner_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: arithmetic scan/banner model plus random stimulus.
// Expectations follow DISPLAY_LZS_EN when it is defined for the build.
module tb_display_scan_mux;
    import display_pkg::*;

    localparam int ND = 4;
    localparam int NS = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int CW = 5;
    localparam int F  = ND * SD;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic [NS*ND*4-1:0]  src_digits = '0;
    logic [NS*ND*CW-1:0] name_codes = '0;
    logic [1:0]          mode_sel = '0;
    logic                name_req = 1'b0;
    logic [CW-1:0]       digit_code;
    logic [ND-1:0]       digit_en;
    logic                banner_active;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;   // clock edges since reset release
    int mode_m  = 0;
    int ban_end = 0;   // banner counter is nonzero after edge e iff e < ban_end
    int cap [ND];

    display_scan_mux #(
        .NUM_DIGITS    (ND),
        .NUM_SRC       (NS),
        .SCAN_DIV      (SD),
        .BANNER_FRAMES (BF),
        .CODE_W        (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_digits    (src_digits),
        .name_codes    (name_codes),
        .mode_sel      (mode_sel),
        .name_req      (name_req),
        .digit_code    (digit_code),
        .digit_en      (digit_en),
        .banner_active (banner_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    function automatic int nib(input int m, input int d);
        return int'(src_digits[(m*ND + d)*4 +: 4]);
    endfunction

    function automatic int name_of(input int m, input int d);
        return int'(name_codes[(m*ND + d)*CW +: CW]);
    endfunction

    function automatic int exp_data(input int m, input int d);
        int  v;
        bit  lead;
        v = nib(m, d);
        if (v > 9) return 31;
`ifdef DISPLAY_LZS_EN
        lead = 1'b1;
        for (int j = 0; j <= d; j++) if (nib(m, j) != 0) lead = 1'b0;
        if (lead && d != ND - 1) return 31;
`else
        lead = 1'b0;
        if (lead) return 31;
`endif
        return v;
    endfunction

    task automatic set_src(input int m, input int d0, input int d1, input int d2, input int d3);
        src_digits[(m*ND + 0)*4 +: 4] = 4'(d0);
        src_digits[(m*ND + 1)*4 +: 4] = 4'(d1);
        src_digits[(m*ND + 2)*4 +: 4] = 4'(d2);
        src_digits[(m*ND + 3)*4 +: 4] = 4'(d3);
    endtask

    // One clock: predict outputs from pre-edge model state and sampled inputs, then compare.
    task automatic tick();
        int idx_p;
        int en_e;
        int code_e;
        bit ban_e;
        @(posedge clk);
        k++;
        idx_p  = ((k - 1) / SD) % ND;
        ban_e  = ((k - 1) < ban_end) || name_req;
        en_e   = 1 << idx_p;
        code_e = ban_e ? name_of(mode_m, idx_p) : exp_data(mode_m, idx_p);
        if (int'(mode_sel) != mode_m && int'(mode_sel) < NS) begin
            mode_m  = int'(mode_sel);
            ban_end = (k / F + BF) * F;
        end
        #1;
        chk("digit_en", int'(digit_en), en_e);
        chk("banner_active", int'(banner_active), int'(ban_e));
        chk("digit_code", int'(digit_code), code_e);
    endtask

    task automatic run_to(input int edge_no);
        while (k < edge_no) tick();
    endtask

    task automatic capture_frame();
        for (int i = 0; i < F; i++) begin
            tick();
            for (int d = 0; d < ND; d++) if (digit_en == ND'(1 << d)) cap[d] = int'(digit_code);
        end
    endtask

    initial begin
        name_codes = BANNER_DEFAULT;
        src_digits = {$urandom, $urandom};
        set_src(0, 1, 2, 3, 4);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_code", int'(digit_code), 31);
        chk("reset_en", int'(digit_en), 0);
        chk("reset_banner", int'(banner_active), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan of mode 0 = {1,2,3,4}
        tick();
        chk("scan_en0", int'(digit_en), 1);  chk("scan_code0", int'(digit_code), 1);
        run_to(5);
        chk("scan_en1", int'(digit_en), 2);  chk("scan_code1", int'(digit_code), 2);
        run_to(9);
        chk("scan_en2", int'(digit_en), 4);  chk("scan_code2", int'(digit_code), 3);
        run_to(13);
        chk("scan_en3", int'(digit_en), 8);  chk("scan_code3", int'(digit_code), 4);
        chk("scan_banner", int'(banner_active), 0);

        // Mode 0 -> 2 mid-frame, sampled at edge 19; banner ends after frame_end at 48
        run_to(18);
        mode_sel = 2'd2;
        tick();
        chk("ban_start_lag", int'(banner_active), 0);
        tick();
        chk("ban_start", int'(banner_active), 1);
        chk("ban_name_A", int'(digit_code), 17);
        run_to(48);
        chk("ban_last", int'(banner_active), 1);
        tick();
        chk("ban_end", int'(banner_active), 0);

        // Change at 53 (ends 80), re-change at 70 extends to 96
        run_to(52);
        mode_sel = 2'd1;
        run_to(69);
        mode_sel = 2'd3;
        run_to(81);
        chk("ban_extended", int'(banner_active), 1);
        chk("ban_name_C", int'(digit_code), 12);
        run_to(96);
        chk("ban_ext_last", int'(banner_active), 1);
        tick();
        chk("ban_ext_end", int'(banner_active), 0);

        // Randomised traffic
        name_codes = 80'({$urandom, $urandom, $urandom});
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(7) == 0)  src_digits = {$urandom, $urandom};
            if ($urandom_range(15) == 0) name_req = ~name_req;
            if ($urandom_range(39) == 0) mode_sel = 2'($urandom_range(3));
            tick();
        end
        name_req   = 1'b0;
        name_codes = BANNER_DEFAULT;

        // name_req held for 10 frames on source 3 with digit 2 = 0xB
        mode_sel = 2'd3;
        set_src(3, 1, 2, 11, 4);
        name_req = 1'b1;
        repeat (10 * F) tick();
        chk("name_req_hold", int'(banner_active), 1);
        name_req = 1'b0;
        repeat (3 * F) tick();
        capture_frame();
        chk("blank_nibble", cap[2], 31);
        chk("data_after_req", cap[3], 4);

        // Leading-zero handling on source 0
        mode_sel = 2'd0;
        set_src(0, 0, 0, 0, 0);
        repeat (3 * F) tick();
        capture_frame();
`ifdef DISPLAY_LZS_EN
        chk("lzs0_d0", cap[0], 31); chk("lzs0_d1", cap[1], 31);
        chk("lzs0_d2", cap[2], 31); chk("lzs0_d3", cap[3], 0);
`else
        chk("lzs0_d0", cap[0], 0);  chk("lzs0_d1", cap[1], 0);
        chk("lzs0_d2", cap[2], 0);  chk("lzs0_d3", cap[3], 0);
`endif
        set_src(0, 0, 5, 0, 7);
        repeat (4) tick();
        capture_frame();
`ifdef DISPLAY_LZS_EN
        chk("lzs1_d0", cap[0], 31);
`else
        chk("lzs1_d0", cap[0], 0);
`endif
        chk("lzs1_d1", cap[1], 5); chk("lzs1_d2", cap[2], 0); chk("lzs1_d3", cap[3], 7);

        // Asynchronous reset in the middle of a banner
        mode_sel = 2'd1;
        repeat (6) tick();
        chk("pre_rst_banner", int'(banner_active), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_code", int'(digit_code), 31);
        chk("arst_en", int'(digit_en), 0);
        chk("arst_banner", int'(banner_active), 0);
        mode_sel = 2'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        k       = 0;
        mode_m  = 0;
        ban_end = 0;
        tick();
        chk("post_rst_en", int'(digit_en), 1);
        chk("post_rst_banner", int'(banner_active), 0);
        repeat (2 * F) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Parametrised successor to the watch's four-digit BCD display multiplexer. It owns the digit-scan timing and selects one of `NUM_SRC` mode sources (clock, stopwatch, alarm, countdown, …) per digit slot. On every mode change it shows a timed mode-name banner. It sits between the mode counters and the seven-segment decoder/anode drivers.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digit positions scanned; index 0 is the most significant (leftmost) digit.
- `NUM_SRC`, 4: number of mode sources.
- `SCAN_DIV`, 1000: `clk` cycles each digit is lit; must be ≥ 2.
- `BANNER_FRAMES`, 256: full scan frames the name banner persists after a mode change; must be ≥ 1.
- `CODE_W`, 5: width of the display code sent to the segment decoder.

Ports (clock and reset first):
- `clk`, in, 1: single system clock; all state is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `src_digits`, in, `NUM_SRC*NUM_DIGITS*4`: BCD nibbles; source s, digit d at bits `[(s*NUM_DIGITS+d)*4 +: 4]`.
- `name_codes`, in, `NUM_SRC*NUM_DIGITS*CODE_W`: banner codes, same packing with `CODE_W`-bit fields.
- `mode_sel`, in, `$clog2(NUM_SRC)`: requested source.
- `name_req`, in, 1: level; forces the banner while high.
- `digit_code`, out, `CODE_W`: code for the currently lit digit.
- `digit_en`, out, `NUM_DIGITS`: one-hot, active-high digit enable.
- `banner_active`, out, 1: high while banner codes are being driven.

## Operation
- Prescaler `pre` counts 0..`SCAN_DIV`-1. On wrap, digit index `idx` advances 0..`NUM_DIGITS`-1 and wraps. Wrap from the last digit to 0 is `frame_end`.
- Mode register `mode_q`: when `mode_sel` ≠ `mode_q` and `mode_sel` < `NUM_SRC`, load `mode_sel` and load banner counter `ban_cnt` with `BANNER_FRAMES`. Out-of-range `mode_sel` is ignored; `mode_q` is held.
- `ban_cnt` decrements on each `frame_end` while nonzero. A mode change during a banner reloads it. A mode change coinciding with `frame_end` reloads it without decrementing.
- Banner state is `ban_cnt` ≠ 0 OR `name_req`. If `name_req` is released with `ban_cnt` = 0, the display returns to data on the next cycle.
- Data mode: for a nibble of 0–9, `digit_code` = zero-extended nibble. For nibbles 10–15, `digit_code` = `CODE_BLANK` (all ones).
- Banner mode: `digit_code` = `name_codes` field for (`mode_q`, `idx`), passed through unmodified.
- Outputs are registered from `idx`, `mode_q` and the banner state every cycle. Source-data changes appear after 1 cycle.

## Timing
- Reset values: `digit_code` = `CODE_BLANK`, `digit_en` = 0, `banner_active` = 0, `pre` = 0, `idx` = 0, `mode_q` = 0, `ban_cnt` = 0. No banner is shown out of reset.
- First cycle after `rst_n` deasserts: `digit_en` = 1 (digit 0).
- `digit_en` changes exactly 1 cycle after the `pre` wrap that changes `idx`. Each digit is lit for `SCAN_DIV` cycles; a frame is `NUM_DIGITS*SCAN_DIV` cycles.
- `mode_sel` change at edge N: `mode_q` updates at N+1; `banner_active` and the name codes appear at N+2. Scan phase is not disturbed.
- Banner length: from the reload, `BANNER_FRAMES` `frame_end` events; `banner_active` falls 1 cycle after the last one. Total duration is 1 partial frame plus `BANNER_FRAMES`-1 full frames.
- Reset mid-operation clears all state immediately (asynchronous); outputs return to reset values.

## Configuration
- `DISPLAY_LZS_EN` defined: leading-zero suppression in data mode only. Digits 0..k that are zero and precede the first nonzero digit output `CODE_BLANK`. Digit `NUM_DIGITS`-1 is never suppressed. Nibbles 10–15 count as nonzero for this purpose.
- Undefined: every digit 0–9 is shown as-is.

## Structure
- Package `display_pkg`: `CODE_BLANK`, letter codes (C=12, L=11, O=20, S=15, t=14, P=13, A=17, r=16, n=18, u=19), and default banner vectors for the four standard modes.
- One sub-module, `scan_timer`: owns `pre`, `idx` and the `frame_end` pulse, parametrised by `NUM_DIGITS` and `SCAN_DIV`.

## Test plan
All scenarios use `NUM_DIGITS`=4, `NUM_SRC`=4, `SCAN_DIV`=4, `BANNER_FRAMES`=2.
- Reset, then run with mode 0 digits {1,2,3,4} -> `digit_en` cycles 0001, 0010, 0100, 1000 every 4 cycles; `digit_code` is 1, 2, 3, 4; `banner_active` = 0.
- Switch `mode_sel` 0→2 mid-frame -> name codes appear 2 cycles later and persist until 1 cycle after the 2nd `frame_end`; source 2's data follows.
- Second mode change during the banner -> `ban_cnt` reloads to 2; the banner is extended with the new source's names.
- `mode_sel` = 3 while source 3's nibble is 0xB, then `name_req` held for 10 frames -> the banner is held for all 10 frames, then data resumes with that digit = 31 (`CODE_BLANK`).
- With `DISPLAY_LZS_EN`, source digits {0,0,0,0} -> codes 31, 31, 31, 0; digits {0,5,0,7} -> codes 31, 5, 0, 7. Without the macro -> codes 0, 0, 0, 0.
- Assert `rst_n` low mid-banner -> next cycle all outputs are at reset values; after release, `digit_en` = 0001 and there is no banner.
